regfile_mp_sb: RTL and testbench

- Parametrised multi-port integer register file for the rapid core, with a per-register pending-write scoreboard.
- Provides NUM_RD combinational read ports with write-to-read bypass and NUM_WR synchronous write ports.
- The issue stage uses the scoreboard to detect RAW hazards on registers whose writeback is still outstanding.
- Sits between decode/issue (reads, issue marks) and writeback (writes, scoreboard clears).

---
 rtl/regfile_mp_sb_if.sv | 54 +++++
 rtl/regfile_mp_sb.sv | 112 +++++++++++
 tb/tb_regfile_mp_sb.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_sb_if.sv
// ---------------------------------------------------------------------------
// regfile_mp_sb_if
// Bundles the read, write, issue and scoreboard signals of the rapid core
// register file.
//
// Signal groups (master = decode/issue + writeback, slave = register file):
//   i_rs          NUM_RD x AW    read addresses                 (master -> slave)
//   o_rs_data     NUM_RD x XLEN  read data, combinational       (slave -> master)
//   o_rs_ready    NUM_RD         1 = read data has no outstanding write
//   i_we          NUM_WR         write enables                  (master -> slave)
//   i_rd          NUM_WR x AW    write addresses
//   i_rd_data     NUM_WR x XLEN  write data
//   i_issue_valid 1              issue of an instruction with a destination
//   i_issue_rd    AW             destination of the issued instruction
//   i_flush       1              clear every pending bit
//   o_pending     DEPTH          registered scoreboard vector   (slave -> master)
//   o_pending_cnt CW             registered popcount of o_pending
//
// Timing contract: there is no backpressure. i_we[w] and i_issue_valid act as
// single-cycle strobes sampled on the rising clock edge; the register file is
// always ready, so every strobe seen at an edge takes effect at that edge.
// Read outputs are valid in the same cycle as their address.
// ---------------------------------------------------------------------------
interface regfile_mp_sb_if #(
   parameter int XLEN   = 32,
   parameter int DEPTH  = 32,
   parameter int NUM_RD = 2,
   parameter int NUM_WR = 1
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [NUM_RD-1:0][AW-1:0]   i_rs;
   logic [NUM_RD-1:0][XLEN-1:0] o_rs_data;
   logic [NUM_RD-1:0]           o_rs_ready;
   logic [NUM_WR-1:0]           i_we;
   logic [NUM_WR-1:0][AW-1:0]   i_rd;
   logic [NUM_WR-1:0][XLEN-1:0] i_rd_data;
   logic                        i_issue_valid;
   logic [AW-1:0]               i_issue_rd;
   logic                        i_flush;
   logic [DEPTH-1:0]            o_pending;
   logic [CW-1:0]               o_pending_cnt;

   modport master (
      output i_rs, i_we, i_rd, i_rd_data, i_issue_valid, i_issue_rd, i_flush,
      input  o_rs_data, o_rs_ready, o_pending, o_pending_cnt
   );

   modport slave (
      input  i_rs, i_we, i_rd, i_rd_data, i_issue_valid, i_issue_rd, i_flush,
      output o_rs_data, o_rs_ready, o_pending, o_pending_cnt
   );
endinterface

// File: rtl/regfile_mp_sb.sv
// ---------------------------------------------------------------------------
// regfile_mp_sb
// Multi-port integer register file with write-to-read bypass and a
// per-register pending-write scoreboard used by issue to detect RAW hazards.
//
// Ports:
//   i_clk    clock, all state updates on the rising edge
//   i_reset  asynchronous active-high reset
//   bus      regfile_mp_sb_if.slave: read ports, write ports, issue marks,
//            flush, scoreboard vector and its popcount
// ---------------------------------------------------------------------------
module regfile_mp_sb #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 32,
   parameter int              NUM_RD   = 2,
   parameter int              NUM_WR   = 1,
   parameter bit              ZERO_REG = 1'b1,
   parameter int              SP_INDEX = 2,
   // Stack pointer reset value of the rapid core.
   parameter logic [XLEN-1:0] RESET_SP = XLEN'(32'h0001_0000)
) (
   input  logic           i_clk,
   input  logic           i_reset,
   regfile_mp_sb_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [DEPTH-1:0][XLEN-1:0]  regs_q, regs_d;
   logic [DEPTH-1:0]            pending_q, pending_d;
   logic [CW-1:0]               cnt_q, cnt_d;
   logic [NUM_WR-1:0]           wr_eff;
   logic [NUM_RD-1:0][XLEN-1:0] rd_data;
   logic [NUM_RD-1:0]           rd_ready;

   // A write to register 0 is discarded when it is hardwired to zero.
   always_comb begin
      wr_eff = '0;
      for (int w = 0; w < NUM_WR; w++)
         wr_eff[w] = bus.i_we[w] && !(ZERO_REG && (bus.i_rd[w] == '0));
   end

   // Read ports. Later loop iterations overwrite earlier ones, so the
   // highest-index matching write port supplies the bypass data, and the
   // zero-register check placed last overrides everything.
   always_comb begin
      rd_data  = '0;
      rd_ready = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         rd_data[k]  = regs_q[bus.i_rs[k]];
         rd_ready[k] = !pending_q[bus.i_rs[k]];
         for (int w = 0; w < NUM_WR; w++) begin
            if (wr_eff[w] && (bus.i_rd[w] == bus.i_rs[k])) begin
               rd_data[k]  = bus.i_rd_data[w];
               rd_ready[k] = 1'b1;
            end
         end
         if (ZERO_REG && (bus.i_rs[k] == '0)) begin
            rd_data[k]  = '0;
            rd_ready[k] = 1'b1;
         end
      end
   end

   // Register array next state; highest write port wins on address clashes.
   always_comb begin
      regs_d = regs_q;
      for (int w = 0; w < NUM_WR; w++)
         if (wr_eff[w])
            regs_d[bus.i_rd[w]] = bus.i_rd_data[w];
   end

   // Scoreboard next state. Flush dominates; an issue beats a same-cycle
   // write to the same register because the issued instruction is the
   // newer producer. The count is taken from the next-state vector so the
   // registered count always matches the registered vector.
   always_comb begin
      pending_d = pending_q;
      cnt_d     = '0;
      for (int r = 0; r < DEPTH; r++) begin
         if (bus.i_flush) begin
            pending_d[r] = 1'b0;
         end else if (bus.i_issue_valid && (bus.i_issue_rd == AW'(r)) &&
                      !(ZERO_REG && (r == 0))) begin
            pending_d[r] = 1'b1;
         end else begin
            for (int w = 0; w < NUM_WR; w++)
               if (wr_eff[w] && (bus.i_rd[w] == AW'(r)))
                  pending_d[r] = 1'b0;
         end
         cnt_d = cnt_d + CW'(pending_d[r]);
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         for (int r = 0; r < DEPTH; r++)
            regs_q[r] <= (r == SP_INDEX) ? RESET_SP : '0;
         pending_q <= '0;
         cnt_q     <= '0;
      end else begin
         regs_q    <= regs_d;
         pending_q <= pending_d;
         cnt_q     <= cnt_d;
      end
   end

   assign bus.o_rs_data     = rd_data;
   assign bus.o_rs_ready    = rd_ready;
   assign bus.o_pending     = pending_q;
   assign bus.o_pending_cnt = cnt_q;
endmodule

// File: tb/tb_regfile_mp_sb.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp_sb
// Directed bench for regfile_mp_sb with two read and two write ports.
// ---------------------------------------------------------------------------
module tb_regfile_mp_sb;
   localparam int              XLEN   = 32;
   localparam int              DEPTH  = 32;
   localparam int              NUM_RD = 2;
   localparam int              NUM_WR = 2;
   localparam logic [XLEN-1:0] SP_VAL = 32'h0001_0000;

   logic clk;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   regfile_mp_sb_if #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) bus ();

   regfile_mp_sb #(
      .XLEN(XLEN), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR),
      .ZERO_REG(1'b1), .SP_INDEX(2), .RESET_SP(SP_VAL)
   ) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.i_we          = '0;
      bus.i_rd          = '0;
      bus.i_rd_data     = '0;
      bus.i_issue_valid = 1'b0;
      bus.i_issue_rd    = '0;
      bus.i_flush       = 1'b0;
   endtask

   task automatic wr(input int port, input logic [4:0] a, input logic [XLEN-1:0] d);
      bus.i_we[port]      = 1'b1;
      bus.i_rd[port]      = a;
      bus.i_rd_data[port] = d;
   endtask

   task automatic issue(input logic [4:0] a);
      bus.i_issue_valid = 1'b1;
      bus.i_issue_rd    = a;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      idle();
      bus.i_rs = '0;
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      bus.i_rs[0] = 5'd2;
      bus.i_rs[1] = 5'd5;
      #1;
      checks++; if (bus.o_rs_data[0] !== SP_VAL) begin errors++;
         $display("FAIL reset_sp: got %h expected %h", bus.o_rs_data[0], SP_VAL); end
      checks++; if (bus.o_rs_ready[0] !== 1'b1) begin errors++;
         $display("FAIL reset_sp_ready: got %b expected 1", bus.o_rs_ready[0]); end
      checks++; if (bus.o_rs_data[1] !== 32'h0) begin errors++;
         $display("FAIL reset_x5: got %h expected 0", bus.o_rs_data[1]); end
      checks++; if (bus.o_pending_cnt !== 6'd0) begin errors++;
         $display("FAIL reset_cnt: got %0d expected 0", bus.o_pending_cnt); end
      checks++; if (bus.o_pending !== 32'h0) begin errors++;
         $display("FAIL reset_pending: got %h expected 0", bus.o_pending); end
   endtask

   task automatic test_bypass();
      idle();
      wr(0, 5'd7, 32'hDEAD_BEEF);
      bus.i_rs[0] = 5'd7;
      #1;
      checks++; if (bus.o_rs_data[0] !== 32'hDEAD_BEEF) begin errors++;
         $display("FAIL bypass_data: got %h expected deadbeef", bus.o_rs_data[0]); end
      checks++; if (bus.o_rs_ready[0] !== 1'b1) begin errors++;
         $display("FAIL bypass_ready: got %b expected 1", bus.o_rs_ready[0]); end
      tick();
      idle();
      #1;
      checks++; if (bus.o_rs_data[0] !== 32'hDEAD_BEEF) begin errors++;
         $display("FAIL x7_stored: got %h expected deadbeef", bus.o_rs_data[0]); end
      wr(0, 5'd0, 32'h1234);
      bus.i_rs[0] = 5'd0;
      #1;
      checks++; if (bus.o_rs_data[0] !== 32'h0) begin errors++;
         $display("FAIL x0_bypass: got %h expected 0", bus.o_rs_data[0]); end
      tick();
      idle();
      #1;
      checks++; if (bus.o_rs_data[0] !== 32'h0) begin errors++;
         $display("FAIL x0_stored: got %h expected 0", bus.o_rs_data[0]); end
   endtask

   task automatic test_dual_write();
      idle();
      wr(0, 5'd9, 32'h11);
      wr(1, 5'd9, 32'h22);
      bus.i_rs[1] = 5'd9;
      #1;
      checks++; if (bus.o_rs_data[1] !== 32'h22) begin errors++;
         $display("FAIL dual_bypass: got %h expected 22", bus.o_rs_data[1]); end
      tick();
      idle();
      #1;
      checks++; if (bus.o_rs_data[1] !== 32'h22) begin errors++;
         $display("FAIL dual_stored: got %h expected 22", bus.o_rs_data[1]); end
      // Bypass must select by address: port 0 hits x10 even though port 1 is active on x9.
      wr(0, 5'd10, 32'hA0);
      wr(1, 5'd9, 32'h33);
      bus.i_rs[0] = 5'd10;
      #1;
      checks++; if (bus.o_rs_data[0] !== 32'hA0) begin errors++;
         $display("FAIL port0_bypass: got %h expected a0", bus.o_rs_data[0]); end
      checks++; if (bus.o_rs_data[1] !== 32'h33) begin errors++;
         $display("FAIL port1_bypass: got %h expected 33", bus.o_rs_data[1]); end
      tick();
      idle();
   endtask

   task automatic test_scoreboard();
      idle();
      issue(5'd5);
      bus.i_rs[0] = 5'd5;
      #1;
      checks++; if (bus.o_rs_ready[0] !== 1'b1) begin errors++;
         $display("FAIL issue_same_cycle_ready: got %b expected 1", bus.o_rs_ready[0]); end
      tick();
      idle();
      #1;
      checks++; if (bus.o_pending !== 32'h0000_0020) begin errors++;
         $display("FAIL issue_pending: got %h expected 00000020", bus.o_pending); end
      checks++; if (bus.o_pending_cnt !== 6'd1) begin errors++;
         $display("FAIL issue_cnt: got %0d expected 1", bus.o_pending_cnt); end
      checks++; if (bus.o_rs_ready[0] !== 1'b0) begin errors++;
         $display("FAIL pending_ready: got %b expected 0", bus.o_rs_ready[0]); end
      wr(0, 5'd5, 32'h55);
      #1;
      checks++; if (bus.o_rs_data[0] !== 32'h55) begin errors++;
         $display("FAIL wb_bypass_data: got %h expected 55", bus.o_rs_data[0]); end
      checks++; if (bus.o_rs_ready[0] !== 1'b1) begin errors++;
         $display("FAIL wb_bypass_ready: got %b expected 1", bus.o_rs_ready[0]); end
      tick();
      idle();
      #1;
      checks++; if (bus.o_pending !== 32'h0) begin errors++;
         $display("FAIL wb_clear_pending: got %h expected 0", bus.o_pending); end
      checks++; if (bus.o_pending_cnt !== 6'd0) begin errors++;
         $display("FAIL wb_clear_cnt: got %0d expected 0", bus.o_pending_cnt); end
   endtask

   task automatic test_issue_vs_write();
      idle();
      issue(5'd6);
      wr(0, 5'd6, 32'h66);
      tick();
      idle();
      bus.i_rs[0] = 5'd6;
      #1;
      checks++; if (bus.o_pending !== 32'h0000_0040) begin errors++;
         $display("FAIL issue_beats_write: got %h expected 00000040", bus.o_pending); end
      checks++; if (bus.o_rs_data[0] !== 32'h66) begin errors++;
         $display("FAIL issue_write_data: got %h expected 66", bus.o_rs_data[0]); end
      checks++; if (bus.o_rs_ready[0] !== 1'b0) begin errors++;
         $display("FAIL issue_write_ready: got %b expected 0", bus.o_rs_ready[0]); end
      issue(5'd0);
      tick();
      idle();
      #1;
      checks++; if (bus.o_pending !== 32'h0000_0040) begin errors++;
         $display("FAIL issue_x0: got %h expected 00000040", bus.o_pending); end
      // Re-issue to an already pending register: still one bit, cleared by one write.
      issue(5'd6);
      tick();
      idle();
      #1;
      checks++; if (bus.o_pending_cnt !== 6'd1) begin errors++;
         $display("FAIL reissue_cnt: got %0d expected 1", bus.o_pending_cnt); end
      wr(1, 5'd6, 32'h67);
      tick();
      idle();
      #1;
      checks++; if (bus.o_pending !== 32'h0) begin errors++;
         $display("FAIL reissue_clear: got %h expected 0", bus.o_pending); end
   endtask

   task automatic test_flush();
      idle();
      issue(5'd3); tick();
      issue(5'd4); tick();
      issue(5'd8); tick();
      idle();
      #1;
      checks++; if (bus.o_pending !== 32'h0000_0118) begin errors++;
         $display("FAIL three_pending: got %h expected 00000118", bus.o_pending); end
      checks++; if (bus.o_pending_cnt !== 6'd3) begin errors++;
         $display("FAIL three_cnt: got %0d expected 3", bus.o_pending_cnt); end
      bus.i_flush = 1'b1;
      issue(5'd10);
      wr(0, 5'd11, 32'hAB);
      tick();
      idle();
      bus.i_rs[0] = 5'd11;
      #1;
      checks++; if (bus.o_pending !== 32'h0) begin errors++;
         $display("FAIL flush_pending: got %h expected 0", bus.o_pending); end
      checks++; if (bus.o_pending_cnt !== 6'd0) begin errors++;
         $display("FAIL flush_cnt: got %0d expected 0", bus.o_pending_cnt); end
      checks++; if (bus.o_rs_data[0] !== 32'hAB) begin errors++;
         $display("FAIL flush_write_lands: got %h expected ab", bus.o_rs_data[0]); end
   endtask

   task automatic test_async_reset();
      idle();
      issue(5'd12);
      wr(0, 5'd2, 32'h77);
      tick();
      idle();
      bus.i_rs[0] = 5'd2;
      #1;
      checks++; if (bus.o_rs_data[0] !== 32'h77) begin errors++;
         $display("FAIL sp_written: got %h expected 77", bus.o_rs_data[0]); end
      checks++; if (bus.o_pending_cnt !== 6'd1) begin errors++;
         $display("FAIL pre_reset_cnt: got %0d expected 1", bus.o_pending_cnt); end
      // Assert reset well away from any rising edge and look before the next one.
      rst = 1'b1;
      #1;
      checks++; if (bus.o_rs_data[0] !== SP_VAL) begin errors++;
         $display("FAIL async_sp: got %h expected %h", bus.o_rs_data[0], SP_VAL); end
      checks++; if (bus.o_pending !== 32'h0) begin errors++;
         $display("FAIL async_pending: got %h expected 0", bus.o_pending); end
      checks++; if (bus.o_pending_cnt !== 6'd0) begin errors++;
         $display("FAIL async_cnt: got %0d expected 0", bus.o_pending_cnt); end
      tick();
      rst = 1'b0;
      issue(5'd13);
      tick();
      idle();
      #1;
      checks++; if (bus.o_pending !== 32'h0000_2000) begin errors++;
         $display("FAIL post_reset_issue: got %h expected 00002000", bus.o_pending); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst = 1'b0;
      bus.i_rs = '0;
      idle();
      test_reset();
      test_bypass();
      test_dual_write();
      test_scoreboard();
      test_issue_vs_write();
      test_flush();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
